// File: rtl/cnn_pool_pkg.sv
// rtl/cnn_pool_pkg.sv - shared types and sizing helpers for the 3D pooling engine
package cnn_pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ACC,
        ST_STORE,
        ST_FINISH
    } pool_state_e;

    function automatic int out_size(input int conv, input int pool, input int stride);
        return (conv - pool) / stride + 1;
    endfunction

    function automatic int pool_shift(input int pool);
        return 3 * $clog2(pool);
    endfunction

    function automatic int acc_width(input int data, input int pool);
        return data + pool_shift(pool);
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_pool_window_acc.sv
// rtl/cnn_pool_window_acc.sv - per-window max/average accumulator
module cnn_pool_window_acc
    import cnn_pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int POOL_SIZE  = 2,
    localparam int SHIFT     = pool_shift(POOL_SIZE),
    localparam int ACC_W     = acc_width(DATA_WIDTH, POOL_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic                         valid,
    input  logic                         mode,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] result
);

    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sample_ext;

    assign sample_ext = ACC_W'(sample);

    // Average is a floor division by the window volume via arithmetic shift.
    assign result = mode ? DATA_WIDTH'(acc >>> SHIFT) : DATA_WIDTH'(acc);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (init) begin
            acc <= mode ? '0 : ACC_MIN;
        end else if (valid) begin
            if (mode) begin
                acc <= acc + sample_ext;
            end else if (sample_ext > acc) begin
                acc <= sample_ext;
            end
        end
    end

endmodule

// File: rtl/cnn_3d_pool_engine.sv
// rtl/cnn_3d_pool_engine.sv - sequential 3D max/average pooling over a multi-filter volume
module cnn_3d_pool_engine
    import cnn_pool_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CONV_SIZE   = 4,
    parameter int POOL_SIZE   = 2,
    parameter int STRIDE      = 2,
    parameter int NUM_FILTERS = 3,
    localparam int OUT_SIZE   = out_size(CONV_SIZE, POOL_SIZE, STRIDE),
    localparam int NUM_IN     = NUM_FILTERS * CONV_SIZE * CONV_SIZE * CONV_SIZE,
    localparam int NUM_OUT    = NUM_FILTERS * OUT_SIZE * OUT_SIZE * OUT_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic signed [DATA_WIDTH-1:0] conv_result [NUM_IN],
    output logic signed [DATA_WIDTH-1:0] pool_result [NUM_OUT],
    output logic                         busy,
    output logic                         done
);

    localparam int F_W       = cnt_width(NUM_FILTERS);
    localparam int O_W       = cnt_width(OUT_SIZE);
    localparam int P_W       = cnt_width(POOL_SIZE);
    localparam int IN_IDX_W  = cnt_width(NUM_IN);
    localparam int OUT_IDX_W = cnt_width(NUM_OUT);

    localparam logic [F_W-1:0] F_LAST = F_W'(NUM_FILTERS - 1);
    localparam logic [O_W-1:0] O_LAST = O_W'(OUT_SIZE - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(POOL_SIZE - 1);

    pool_state_e state_q, state_d;
    pool_mode_e  mode_q;

    logic [F_W-1:0] f_cnt;
    logic [O_W-1:0] od, orw, oc;
    logic [P_W-1:0] pd, pr, pc;

    logic clear_cnt, acc_init, acc_valid, store_en;
    logic off_last, win_last;
    logic [IN_IDX_W-1:0]  in_sel;
    logic [OUT_IDX_W-1:0] out_sel;
    logic signed [DATA_WIDTH-1:0] acc_result;

    assign off_last = (pd == P_LAST) && (pr == P_LAST) && (pc == P_LAST);
    assign win_last = (f_cnt == F_LAST) && (od == O_LAST) && (orw == O_LAST) && (oc == O_LAST);

    // Flattened f*C^3 + d*C^2 + r*C + c, evaluated in Horner form.
    assign in_sel = IN_IDX_W'(
        ((32'(f_cnt) * CONV_SIZE + 32'(od) * STRIDE + 32'(pd)) * CONV_SIZE
          + 32'(orw) * STRIDE + 32'(pr)) * CONV_SIZE
          + 32'(oc) * STRIDE + 32'(pc));

    assign out_sel = OUT_IDX_W'(
        ((32'(f_cnt) * OUT_SIZE + 32'(od)) * OUT_SIZE + 32'(orw)) * OUT_SIZE + 32'(oc));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clear_cnt = 1'b0;
        acc_init  = 1'b0;
        acc_valid = 1'b0;
        store_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear_cnt = 1'b1;
                    state_d   = ST_INIT;
                end
            end
            ST_INIT: begin
                busy     = 1'b1;
                acc_init = 1'b1;
                state_d  = ST_ACC;
            end
            ST_ACC: begin
                busy      = 1'b1;
                acc_valid = 1'b1;
                if (off_last) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                busy     = 1'b1;
                store_en = 1'b1;
                state_d  = win_last ? ST_FINISH : ST_INIT;
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= POOL_MAX;
            f_cnt  <= '0;
            od     <= '0;
            orw    <= '0;
            oc     <= '0;
            pd     <= '0;
            pr     <= '0;
            pc     <= '0;
        end else begin
            if (clear_cnt) begin
                mode_q <= pool_mode_e'(mode);
                f_cnt  <= '0;
                od     <= '0;
                orw    <= '0;
                oc     <= '0;
            end

            if (acc_init) begin
                pd <= '0;
                pr <= '0;
                pc <= '0;
            end else if (acc_valid) begin
                if (pc == P_LAST) begin
                    pc <= '0;
                    if (pr == P_LAST) begin
                        pr <= '0;
                        pd <= pd + 1'b1;
                    end else begin
                        pr <= pr + 1'b1;
                    end
                end else begin
                    pc <= pc + 1'b1;
                end
            end

            if (store_en) begin
                if (oc == O_LAST) begin
                    oc <= '0;
                    if (orw == O_LAST) begin
                        orw <= '0;
                        if (od == O_LAST) begin
                            od    <= '0;
                            f_cnt <= f_cnt + 1'b1;
                        end else begin
                            od <= od + 1'b1;
                        end
                    end else begin
                        orw <= orw + 1'b1;
                    end
                end else begin
                    oc <= oc + 1'b1;
                end
            end
        end
    end

    cnn_pool_window_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .POOL_SIZE  (POOL_SIZE)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .init   (acc_init),
        .valid  (acc_valid),
        .mode   (mode_q == POOL_AVG),
        .sample (conv_result[in_sel]),
        .result (acc_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                pool_result[i] <= '0;
            end
        end else if (store_en) begin
            pool_result[out_sel] <= acc_result;
        end
    end

endmodule

// File: tb/tb_cnn_3d_pool_engine.sv
// tb/tb_cnn_3d_pool_engine.sv - randomized model-checked bench for cnn_3d_pool_engine
module tb_cnn_3d_pool_engine;

    logic clk = 1'b0;
    logic reset;
    logic start0, start1;
    logic mode;
    logic signed [15:0] conv0 [192];
    logic signed [15:0] pool0 [24];
    logic signed [15:0] conv1 [192];
    logic signed [15:0] pool1 [81];
    logic busy0, done0, busy1, done1;

    int total = 0;
    int bad = 0;
    int exp_out [81];
    logic prev_done0 = 1'b0;
    logic prev_done1 = 1'b0;

    always #5 clk = ~clk;

    cnn_3d_pool_engine dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start0),
        .mode        (mode),
        .conv_result (conv0),
        .pool_result (pool0),
        .busy        (busy0),
        .done        (done0)
    );

    cnn_3d_pool_engine #(.STRIDE(1)) dut_s1 (
        .clk         (clk),
        .reset       (reset),
        .start       (start1),
        .mode        (mode),
        .conv_result (conv1),
        .pool_result (pool1),
        .busy        (busy1),
        .done        (done1)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // done must never stay high two cycles in a row
    always @(negedge clk) begin
        if (prev_done0) check("done0_pulse", int'(done0), 0);
        if (prev_done1) check("done1_pulse", int'(done1), 0);
        prev_done0 = done0;
        prev_done1 = done1;
    end

    task automatic model_calc(input int sel, input bit avg);
        int st, os, v, acc, q, idx;
        st = sel ? 1 : 2;
        os = (4 - 2) / st + 1;
        for (int f = 0; f < 3; f++)
        for (int d = 0; d < os; d++)
        for (int r = 0; r < os; r++)
        for (int c = 0; c < os; c++) begin
            acc = avg ? 0 : -(1 << 30);
            for (int wd = 0; wd < 2; wd++)
            for (int wr = 0; wr < 2; wr++)
            for (int wc = 0; wc < 2; wc++) begin
                idx = f * 64 + (d * st + wd) * 16 + (r * st + wr) * 4 + (c * st + wc);
                v = sel ? int'(conv1[idx]) : int'(conv0[idx]);
                if (avg) acc = acc + v;
                else if (v > acc) acc = v;
            end
            if (avg) begin
                q = acc / 8;
                if ((acc % 8 != 0) && (acc < 0)) q = q - 1;
            end else begin
                q = acc;
            end
            exp_out[((f * os + d) * os + r) * os + c] = q;
        end
    endtask

    task automatic run(input int sel, input bit m, input bit poke);
        int lat, exp_lat, nout, act;
        logic dn, bz;
        nout = sel ? 81 : 24;
        exp_lat = nout * 10 + 1;
        lat = 0;
        @(negedge clk);
        mode = m;
        if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        mode = ~m;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            dn = sel ? done1 : done0;
            bz = sel ? busy1 : busy0;
            if (dn) begin
                lat = cyc;
                break;
            end
            check($sformatf("busy_c%0d", cyc), int'(bz), 1);
            if (poke && (cyc == 5 || cyc == 100)) begin
                if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
                mode = $urandom_range(0, 1);
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        start1 = 1'b0;
        if (lat == 0) check("done_timeout", 0, 1);
        else check("latency", lat, exp_lat);
        @(negedge clk);
        check("idle_busy", int'(sel ? busy1 : busy0), 0);
        model_calc(sel, m);
        for (int i = 0; i < nout; i++) begin
            act = sel ? int'(pool1[i]) : int'(pool0[i]);
            check($sformatf("out%0d_m%0d_s%0d", i, m, sel), act, exp_out[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode = 1'b0;
        for (int i = 0; i < 192; i++) begin
            conv0[i] = '0;
            conv1[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy0", int'(busy0), 0);
        check("rst_done0", int'(done0), 0);
        check("rst_busy1", int'(busy1), 0);
        for (int i = 0; i < 24; i++) check($sformatf("rst_out%0d", i), int'(pool0[i]), 0);
        reset = 1'b0;

        for (int i = 0; i < 192; i++) conv0[i] = 16'(i - 96);
        run(0, 1'b0, 1'b0);
        check("lit_max_p0", int'(pool0[0]), -75);
        check("lit_max_p23", int'(pool0[23]), 95);
        run(0, 1'b1, 1'b0);
        check("lit_avg_p0", int'(pool0[0]), -86);

        for (int i = 0; i < 192; i++) conv1[i] = 16'(i);
        run(1, 1'b0, 1'b0);
        check("lit_s1_p0", int'(pool1[0]), 21);
        check("lit_s1_p80", int'(pool1[80]), 191);

        for (int i = 0; i < 192; i++) conv0[i] = -16'sd32768;
        run(0, 1'b0, 1'b0);
        check("lit_min_p7", int'(pool0[7]), -32768);
        for (int i = 0; i < 192; i++) conv0[i] = 16'sd32767;
        run(0, 1'b1, 1'b0);
        check("lit_maxavg_p7", int'(pool0[7]), 32767);

        repeat (4) begin
            for (int i = 0; i < 192; i++) conv0[i] = 16'($urandom);
            run(0, 1'($urandom_range(0, 1)), 1'b1);
        end
        repeat (2) begin
            for (int i = 0; i < 192; i++) conv1[i] = 16'($urandom);
            run(1, 1'($urandom_range(0, 1)), 1'b0);
        end

        // reset mid-run aborts with no done and clears outputs
        for (int i = 0; i < 192; i++) conv0[i] = 16'($urandom);
        @(negedge clk);
        mode = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy0), 0);
        check("abort_done", int'(done0), 0);
        for (int i = 0; i < 24; i++) check($sformatf("abort_out%0d", i), int'(pool0[i]), 0);
        reset = 1'b0;
        dcount = 0;
        repeat (300) begin
            @(negedge clk);
            if (done0) dcount++;
        end
        check("abort_no_done", dcount, 0);
        run(0, 1'($urandom_range(0, 1)), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
